// File: rtl/my_pe_pkg.sv
// Shared definitions for the PE operand feeder: FSM state encoding and
// fp32 / PE timing constants.
package my_pe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [31:0] FP32_ZERO       = 32'h0000_0000;
  // The feeder prefetches the next pair in the cycle after an issue, so the
  // PE result for that issue must not come back any sooner than this.
  localparam int          MIN_FMA_LATENCY = 2;

endpackage

// File: rtl/my_pe_feeder.sv
// Operand sequencer for the FMA processing element. Streams len pairs
// A[i], B[i] out of the operand RAMs into the PE so that the PE's fed-back
// accumulator forms the dot product, then captures the final sum.
module my_pe_feeder
  import my_pe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int L_RAM_SIZE = 6
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [L_RAM_SIZE:0]   len,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [L_RAM_SIZE-1:0] a_addr,
  output logic [L_RAM_SIZE-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] a_rddata,
  input  logic [DATA_WIDTH-1:0] b_rddata,
  output logic [DATA_WIDTH-1:0] pe_ain,
  output logic [DATA_WIDTH-1:0] pe_bin,
  output logic                  pe_valid,
  input  logic                  pe_dvalid,
  input  logic [DATA_WIDTH-1:0] pe_dout
);

  localparam int                CW      = L_RAM_SIZE + 1;
  localparam logic [CW-1:0]     MAX_LEN = {1'b1, {L_RAM_SIZE{1'b0}}};

  state_e                  state;
  logic [CW-1:0]           len_q;       // effective (saturated) vector length
  logic [CW-1:0]           idx;         // next RAM element to read
  logic [CW-1:0]           cnt;         // pairs issued to the PE so far
  logic [L_RAM_SIZE-1:0]   addr_q;      // holds the last valid index, never wraps
  logic                    first_wait;  // first WAIT cycle after an issue
  logic [DATA_WIDTH-1:0]   a_pre;       // prefetch registers drive the PE directly
  logic [DATA_WIDTH-1:0]   b_pre;
  logic [DATA_WIDTH-1:0]   result_q;

  logic [CW-1:0]           len_sat;
  logic [CW-1:0]           idx_nxt;
  logic [CW-1:0]           cnt_nxt;
  logic                    more;        // issues still outstanding

  // Saturate the requested length and derive counter increments.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    len_sat = len;
    if (len > MAX_LEN) len_sat = MAX_LEN;
    idx_nxt = idx + CW'(1);
    cnt_nxt = cnt + CW'(1);
    more    = (cnt < len_q);
  end

  // Issue strobe: one cycle in ISSUE, then exactly on each returning partial sum.
  always_comb begin
    pe_valid = 1'b0;
    if (state == ST_ISSUE) pe_valid = 1'b1;
    else if (state == ST_WAIT && pe_dvalid && more) pe_valid = 1'b1;
  end

  assign done   = (state == ST_DONE);
  assign result = result_q;
  assign a_addr = addr_q;
  assign b_addr = addr_q;
  assign pe_ain = a_pre;
  assign pe_bin = b_pre;

  // Sequencer FSM with its counters, address and prefetch registers.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      idx        <= '0;
      cnt        <= '0;
      addr_q     <= '0;
      first_wait <= 1'b0;
      a_pre      <= '0;
      b_pre      <= '0;
      result_q   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (len == '0) begin
              result_q <= DATA_WIDTH'(FP32_ZERO);
              state    <= ST_DONE;
            end else begin
              len_q  <= len_sat;
              idx    <= '0;
              cnt    <= '0;
              addr_q <= '0;
              state  <= ST_FETCH;
            end
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          a_pre <= a_rddata;
          b_pre <= b_rddata;
          idx   <= idx_nxt;
          if (idx_nxt < len_q) addr_q <= idx_nxt[L_RAM_SIZE-1:0];
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          cnt        <= cnt_nxt;
          first_wait <= 1'b1;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // Data for the address presented during the issue cycle arrives now.
          if (first_wait) begin
            first_wait <= 1'b0;
            if (more) begin
              a_pre <= a_rddata;
              b_pre <= b_rddata;
              idx   <= idx_nxt;
              if (idx_nxt < len_q) addr_q <= idx_nxt[L_RAM_SIZE-1:0];
            end
          end
          if (pe_dvalid) begin
            if (more) begin
              cnt        <= cnt_nxt;
              first_wait <= 1'b1;
            end else begin
              result_q <= pe_dout;
              state    <= ST_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/my_pe_feeder.md
# my_pe_feeder

Operand sequencer directly upstream of the FMA processing element (PE). On `start`, it reads `len` operand pairs A[i], B[i] from two single-port operand RAMs and issues them to the PE so that the PE's fed-back accumulator computes the dot product of A and B. It captures the final PE result and reports `done`. It sits between the AXI-loaded operand RAMs and the PE.

## Interface
- `DATA_WIDTH`, 32, fp32 operand/result width.
- `L_RAM_SIZE`, 6, operand RAM address width; maximum vector length is 2^L_RAM_SIZE.
- `aclk` in 1: the single clock; all logic on the rising edge.
- `aresetn` in 1: reset, asynchronous and active-low.
- `start` in 1: level; sampled only in IDLE.
- `len` in L_RAM_SIZE+1: element count, latched when `start` is accepted.
- `done` out 1: high in DONE; held until the next accepted `start`.
- `result` out DATA_WIDTH: final accumulated value; valid while `done` is high.
- `a_addr`, `b_addr` out L_RAM_SIZE: operand RAM read addresses.
- `a_rddata`, `b_rddata` in DATA_WIDTH: RAM read data, 1-cycle read latency.
- `pe_ain`, `pe_bin` out DATA_WIDTH: PE operands.
- `pe_valid` out 1: PE issue strobe.
- `pe_dvalid` in 1: PE result strobe.
- `pe_dout` in DATA_WIDTH: PE result; the PE forces it to 0 when `pe_dvalid` is low.

## Operation
- PE accumulator rule: the PE samples its addend from its own `pe_dout` when `pe_valid` is high.
  - The first issue must happen while `pe_dvalid` is low, so the addend is 0.
  - Every later issue must be asserted in exactly the cycle `pe_dvalid` is high, so the addend is the previous partial sum.
- States are IDLE, FETCH, LOAD, ISSUE, WAIT and DONE.
- IDLE
  - If `start`=1 and `len`=0: go to DONE with `result`=0.
  - If `start`=1 and `len`≠0: latch `len`, clear index `idx` and issue count `cnt`, go to FETCH.
- FETCH: drive `a_addr`/`b_addr`=`idx`, then go to LOAD.
- LOAD: latch `a_rddata`/`b_rddata` into the prefetch registers, increment `idx`, then go to ISSUE.
- ISSUE
  - `pe_valid`=1 with `pe_ain`/`pe_bin` taken from the prefetch registers.
  - Drive addresses = `idx` (next pair) and increment `cnt`.
  - Go to WAIT.
- WAIT
  - In the first WAIT cycle, latch the RAM data into the prefetch registers and increment `idx`. This happens only if `cnt`<`len`.
  - On `pe_dvalid`=1 with `cnt`<`len`:
    - `pe_valid`=1 combinationally in the same cycle, operands from the prefetch registers.
    - Drive addresses = `idx`, increment `cnt`.
    - Stay in WAIT; its first-cycle prefetch repeats.
  - On `pe_dvalid`=1 with `cnt`=`len`: `result` <= `pe_dout`, go to DONE.
- DONE: `done`=1. `start`=1 restarts exactly as from IDLE.
- `pe_valid` is 0 in every other state and condition. `pe_dvalid` outside WAIT is ignored.
- `start` is ignored in FETCH, LOAD, ISSUE and WAIT.
- `len` > 2^L_RAM_SIZE is saturated to 2^L_RAM_SIZE.
- `idx` never wraps: at most `len` reads are made.
- The PE's FMA latency L must be ≥2 cycles, so the prefetch completes before the next `pe_dvalid`.

## Timing
- Reset values:
  - State IDLE, `done`=0, `result`=0.
  - `pe_valid`=0, `pe_ain`=`pe_bin`=0.
  - `a_addr`=`b_addr`=0, `idx`=`cnt`=0.
  - Prefetch registers 0.
- Asserting `aresetn` mid-operation returns everything to these values immediately. The PE is reset on the same net, so no in-flight result is kept.
- With `start` accepted at edge k:
  - FETCH runs in cycle k+1, LOAD in k+2, and the first issue in k+3.
  - Issue n (n≥1) occurs in cycle k+3+n·L.
  - `done` rises in cycle k+4+len·L.
- `len`=0: `done` rises in cycle k+1.
- `pe_ain`/`pe_bin` are registered. `pe_valid` in WAIT is combinational from `pe_dvalid`; this is the only combinational input-to-output path.

## Structure
- Shared package `my_pe_pkg` holds:
  - the state enum (IDLE, FETCH, LOAD, ISSUE, WAIT, DONE);
  - constants FP32_ZERO = 32'h0000_0000 and MIN_FMA_LATENCY = 2.
- No sub-module. Everything is one FSM plus counters and prefetch registers. The bench instantiates `my_pe` with this block and behavioural RAMs.

## Test plan
- `len`=1, A={2.0}, B={3.0} -> one `pe_valid` pulse with `pe_dvalid` low; `result`=0x40C00000 (6.0); `done` at k+4+L.
- `len`=4, A={1,2,3,4}, B={1,1,1,1} -> 4 issues, issues 2–4 coincident with `pe_dvalid`; `result`=0x41200000 (10.0).
- `len`=0 -> no `pe_valid`, no RAM reads; `done`=1 at k+1 with `result`=0.
- `len`=64 (full RAM), all A=B=1.0 -> `result`=0x42800000 (64.0); max address 63 and no wrap.
- `aresetn` pulsed during WAIT of a `len`=4 run -> all outputs at reset values asynchronously. A new `start` with `len`=2, A={1,1}, B={1,1} then gives `result`=0x40000000 (2.0).
- `start` toggled during WAIT, and a spurious `pe_dvalid` driven in IDLE -> both ignored; no extra `pe_valid`; the original result is unchanged.
